// File: rtl/custom_ctrl_if.sv
// rtl/custom_ctrl_if.sv - start/status, memory read and datapath control bundle for custom_ctrl
interface custom_ctrl_if #(
   parameter int unsigned ADDR_W = 8
);
   logic              start;
   logic              busy;
   logic              done;
   logic              mem_rd;
   logic [ADDR_W-1:0] mem_addr;
   logic [3:0]        weight_en;
   logic [3:0]        feature_en;
   logic [3:0]        buff_mux_sel;
   logic [7:0]        sel_demux;
   logic [3:0]        acc_en;

   modport master (
      input  start,
      output busy, done, mem_rd, mem_addr, weight_en, feature_en,
             buff_mux_sel, sel_demux, acc_en
   );

   modport slave (
      output start,
      input  busy, done, mem_rd, mem_addr, weight_en, feature_en,
             buff_mux_sel, sel_demux, acc_en
   );
endinterface

// File: rtl/custom_ctrl.sv
// rtl/custom_ctrl.sv - sequencer for the 2x2-output convolution datapath (weight/feature loads, accumulate steering)
module custom_ctrl #(
   parameter int unsigned       ADDR_W = 8,
   parameter logic [ADDR_W-1:0] W_BASE = '0,
   parameter logic [ADDR_W-1:0] F_BASE = ADDR_W'(4)
) (
   input  logic            clk,
   input  logic            rst,
   custom_ctrl_if.master   bus
);

   typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_F, WAIT, ACC, DONE} state_t;

   state_t            state_q, state_d;
   logic [1:0]        step_q, step_d;
   logic [1:0]        pos_q, pos_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              mem_rd_q, mem_rd_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [3:0]        weight_en_q, weight_en_d;
   logic [3:0]        feature_en_q, feature_en_d;
   logic [3:0]        buff_mux_sel_q, buff_mux_sel_d;
   logic [7:0]        sel_demux_q, sel_demux_d;
   logic [3:0]        acc_en_q, acc_en_d;
   logic [1:0]        f_row, f_col;
   logic [3:0]        f_off;

   always_comb begin
      state_d = state_q;
      step_d  = step_q;
      pos_d   = pos_q;
      case (state_q)
         IDLE: begin
            if (bus.start) begin
               state_d = LOAD_W;
               step_d  = 2'd0;
               pos_d   = 2'd0;
            end
         end
         LOAD_W: begin
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) state_d = LOAD_F;
         end
         LOAD_F: begin
            step_d = step_q + 2'd1;
            if (step_q == 2'd3) state_d = WAIT;
         end
         WAIT:   state_d = ACC;
         ACC: begin
            if (pos_q == 2'd3) begin
               state_d = DONE;
               pos_d   = 2'd0;
            end else begin
               state_d = LOAD_F;
               pos_d   = pos_q + 2'd1;
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs are decoded from the next state so they appear registered in the cycle they belong to.
   always_comb begin
      f_row          = {1'b0, pos_d[1]} + {1'b0, step_d[1]};
      f_col          = {1'b0, pos_d[0]} + {1'b0, step_d[0]};
      f_off          = {2'b00, f_row} * 4'd3 + {2'b00, f_col};
      busy_d         = (state_d != IDLE);
      done_d         = (state_d == DONE);
      mem_rd_d       = 1'b0;
      mem_addr_d     = '0;
      buff_mux_sel_d = 4'b0000;
      sel_demux_d    = 8'h00;
      acc_en_d       = 4'b0000;
      case (state_d)
         LOAD_W: begin
            mem_rd_d   = 1'b1;
            mem_addr_d = W_BASE + ADDR_W'(step_d);
         end
         LOAD_F: begin
            mem_rd_d   = 1'b1;
            mem_addr_d = F_BASE + ADDR_W'(f_off);
         end
         ACC: begin
            buff_mux_sel_d = 4'b1111;
            sel_demux_d    = {4{pos_d}};
            acc_en_d       = 4'b1000 >> pos_d;
         end
         default: ;
      endcase
      // Load enables trail the address by one cycle, matching the memory read latency.
      weight_en_d  = (state_q == LOAD_W) ? (4'b1000 >> step_q) : 4'b0000;
      feature_en_d = (state_q == LOAD_F) ? (4'b1000 >> step_q) : 4'b0000;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= IDLE;
         step_q         <= 2'd0;
         pos_q          <= 2'd0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         mem_rd_q       <= 1'b0;
         mem_addr_q     <= '0;
         weight_en_q    <= 4'b0000;
         feature_en_q   <= 4'b0000;
         buff_mux_sel_q <= 4'b0000;
         sel_demux_q    <= 8'h00;
         acc_en_q       <= 4'b0000;
      end else begin
         state_q        <= state_d;
         step_q         <= step_d;
         pos_q          <= pos_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         mem_rd_q       <= mem_rd_d;
         mem_addr_q     <= mem_addr_d;
         weight_en_q    <= weight_en_d;
         feature_en_q   <= feature_en_d;
         buff_mux_sel_q <= buff_mux_sel_d;
         sel_demux_q    <= sel_demux_d;
         acc_en_q       <= acc_en_d;
      end
   end

   assign bus.busy         = busy_q;
   assign bus.done         = done_q;
   assign bus.mem_rd       = mem_rd_q;
   assign bus.mem_addr     = mem_addr_q;
   assign bus.weight_en    = weight_en_q;
   assign bus.feature_en   = feature_en_q;
   assign bus.buff_mux_sel = buff_mux_sel_q;
   assign bus.sel_demux    = sel_demux_q;
   assign bus.acc_en       = acc_en_q;

endmodule
